// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg
//   Shared definitions for the 7-segment scanner: scan FSM state encoding,
//   the hex-to-segment table (active-low, bit order gfedcba) and the
//   all-segments-off pattern.
package seven_seg_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_e;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Element [n] holds the active-low pattern (gfedcba) for hex value n.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/seg7_hex_decoder.sv
// seg7_hex_decoder
//   Purely combinational 4-bit hex to 7-segment decoder (active-low).
//   Ports:
//     hex_i  [3:0]  hex value to display
//     seg_o  [6:0]  cathode pattern, seg_o[0]=a ... seg_o[6]=g, 0 = lit
module seg7_hex_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_SEG[hex_i];

endmodule

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner
//   Time-multiplexes NUM_DIGITS hex digits onto a common-anode display,
//   advancing one digit per refresh tick with an all-off blanking gap
//   between digits. A full frame of inputs is captured into shadow
//   registers at frame start so updates never tear mid-scan.
//   Ports:
//     clk          system clock
//     rst_n        asynchronous active-low reset
//     tick         one-cycle refresh pulse
//     digits       4 bits per digit, digit 0 rightmost
//     dp_in        decimal point request per digit (1 = lit)
//     en_mask      digit enable per digit (1 = enabled)
//     an           anode drive, active-low, at most one bit low
//     seg          cathodes, active-low, seg[0]=a ... seg[6]=g
//     dp           decimal point cathode, active-low
//     frame_start  one-cycle pulse when a new frame is captured
//   Build option: SEVEN_SEG_LEADING_ZERO_BLANK_EN suppresses leading zero
//   digits (digit 0 is never suppressed).
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tick,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   en_mask,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_start
);

  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam int unsigned CNT_W = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] BLANK_LD  = CNT_W'(BLANK_CYCLES);

  scan_state_e               state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0]   sh_dig_q, sh_dig_d;
  logic [NUM_DIGITS-1:0]     sh_dp_q, sh_dp_d;
  logic [NUM_DIGITS-1:0]     sh_en_q, sh_en_d;
  logic [NUM_DIGITS-1:0]     an_q, an_d;
  logic [6:0]                seg_q, seg_d;
  logic                      dp_q, dp_d;
  logic                      fs_q, fs_d;
  logic [NUM_DIGITS-1:0]     load_en;
  logic [3:0]                cur_hex;
  logic [6:0]                cur_seg;

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  // Walk down from the most significant digit; a digit is suppressed while
  // it and everything above it are zero. Digit 0 always keeps en_mask[0].
  logic upper_zero;
  always_comb begin
    upper_zero = 1'b1;
    load_en    = en_mask;
    for (int unsigned i = NUM_DIGITS - 1; i >= 1; i--) begin
      upper_zero = upper_zero & (digits[4*i +: 4] == 4'h0);
      if (upper_zero) load_en[i] = 1'b0;
    end
  end
`else
  assign load_en = en_mask;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    sh_dig_d = sh_dig_q;
    sh_dp_d  = sh_dp_q;
    sh_en_d  = sh_en_q;
    fs_d     = 1'b0;
    case (state_q)
      ST_LOAD: begin
        sh_dig_d = digits;
        sh_dp_d  = dp_in;
        sh_en_d  = load_en;
        fs_d     = 1'b1;
        cnt_d    = BLANK_LD;
        state_d  = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;
      end
      ST_BLANK: begin
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = ST_SHOW;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_SHOW: begin
        if (tick) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = ST_LOAD;
          end else begin
            idx_d = idx_q + IDX_W'(1);
            if (BLANK_CYCLES != 0) begin
              cnt_d   = BLANK_LD;
              state_d = ST_BLANK;
            end
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // Outputs are registered from the next-state view so the displayed digit
  // changes on the same edge the FSM enters SHOW (also covers the
  // LOAD->SHOW hop when blanking is disabled, using the freshly loaded frame).
  assign cur_hex = sh_dig_d[{idx_d, 2'b00} +: 4];

  seg7_hex_decoder u_dec (
    .hex_i (cur_hex),
    .seg_o (cur_seg)
  );

  always_comb begin
    an_d  = '1;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (state_d == ST_SHOW) begin
      an_d[idx_d] = ~sh_en_d[idx_d];
      seg_d       = cur_seg;
      dp_d        = ~sh_dp_d[idx_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_LOAD;
      idx_q    <= '0;
      cnt_q    <= '0;
      sh_dig_q <= '0;
      sh_dp_q  <= '0;
      sh_en_q  <= '0;
      an_q     <= '1;
      seg_q    <= SEG_OFF;
      dp_q     <= 1'b1;
      fs_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      sh_dig_q <= sh_dig_d;
      sh_dp_q  <= sh_dp_d;
      sh_en_q  <= sh_en_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      fs_q     <= fs_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
module tb_seven_seg_scanner;

  localparam int unsigned ND = 8;
  localparam int unsigned BC = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tick;
  logic [31:0] digits;
  logic [7:0]  dp_in;
  logic [7:0]  en_mask;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seven_seg_scanner #(
    .NUM_DIGITS   (ND),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .digits      (digits),
    .dp_in       (dp_in),
    .en_mask     (en_mask),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .frame_start (frame_start)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [7:0]  dpi;
    logic [7:0]  en;
    logic        wrap;
    logic [7:0]  ea;
    logic [6:0]  es;
    logic        ed;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the edge that sampled tick.
  task automatic pulse_tick();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic advance(input string tag, input logic wrap,
                         input logic [7:0] ea, input logic [6:0] es, input logic ed);
    pulse_tick();
    chk({tag, " off_first"}, {24'h0, an}, {24'h0, 8'hFF});
    if (wrap) begin
      @(negedge clk);
      chk({tag, " frame_start"}, {31'h0, frame_start}, 32'h1);
    end else begin
      chk({tag, " no_frame_start"}, {31'h0, frame_start}, 32'h0);
    end
    repeat (BC - 1) @(negedge clk);
    chk({tag, " off_last"}, {17'h0, seg, an}, {17'h0, 7'h7F, 8'hFF});
    @(negedge clk);
    chk({tag, " an"}, {24'h0, an}, {24'h0, ea});
    chk({tag, " seg"}, {25'h0, seg}, {25'h0, es});
    chk({tag, " dp"}, {31'h0, dp}, {31'h0, ed});
  endtask

  initial begin
    // Frame A = 0x12345678, then inputs change while digit 3 is on screen.
    tbl[0]  = '{32'h12345678, 8'h00, 8'hFF, 1'b0, 8'hFD, 7'b1111000, 1'b1};
    tbl[1]  = '{32'h12345678, 8'h00, 8'hFF, 1'b0, 8'hFB, 7'b0000010, 1'b1};
    tbl[2]  = '{32'h12345678, 8'h00, 8'hFF, 1'b0, 8'hF7, 7'b0010010, 1'b1};
    tbl[3]  = '{32'hFFFFFFFF, 8'h04, 8'h0F, 1'b0, 8'hEF, 7'b0011001, 1'b1};
    tbl[4]  = '{32'hFFFFFFFF, 8'h04, 8'h0F, 1'b0, 8'hDF, 7'b0110000, 1'b1};
    tbl[5]  = '{32'hFFFFFFFF, 8'h04, 8'h0F, 1'b0, 8'hBF, 7'b0100100, 1'b1};
    tbl[6]  = '{32'hFFFFFFFF, 8'h04, 8'h0F, 1'b0, 8'h7F, 7'b1111001, 1'b1};
    tbl[7]  = '{32'hFFFFFFFF, 8'h04, 8'h0F, 1'b1, 8'hFE, 7'b0001110, 1'b1};
    tbl[8]  = '{32'hFFFFFFFF, 8'h04, 8'h0F, 1'b0, 8'hFD, 7'b0001110, 1'b1};
    tbl[9]  = '{32'hFFFFFFFF, 8'h04, 8'h0F, 1'b0, 8'hFB, 7'b0001110, 1'b0};
    tbl[10] = '{32'hFFFFFFFF, 8'h04, 8'h0F, 1'b0, 8'hF7, 7'b0001110, 1'b1};
    tbl[11] = '{32'hFFFFFFFF, 8'h04, 8'h0F, 1'b0, 8'hFF, 7'b0001110, 1'b1};
    tbl[12] = '{32'hFFFFFFFF, 8'h04, 8'h0F, 1'b0, 8'hFF, 7'b0001110, 1'b1};
    tbl[13] = '{32'hFFFFFFFF, 8'h04, 8'h0F, 1'b0, 8'hFF, 7'b0001110, 1'b1};
    tbl[14] = '{32'hFFFFFFFF, 8'h04, 8'h0F, 1'b0, 8'hFF, 7'b0001110, 1'b1};
    tbl[15] = '{32'h12345678, 8'h00, 8'hFF, 1'b1, 8'hFE, 7'b0000000, 1'b1};

    rst_n   = 1'b0;
    tick    = 1'b0;
    digits  = 32'h12345678;
    dp_in   = 8'h00;
    en_mask = 8'hFF;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst an", {24'h0, an}, 32'hFF);
    chk("rst seg", {25'h0, seg}, 32'h7F);
    chk("rst dp", {31'h0, dp}, 32'h1);
    chk("rst frame_start", {31'h0, frame_start}, 32'h0);

    // First frame after release: LOAD, 16 blank cycles, then digit 0 ("8")
    rst_n = 1'b1;
    @(negedge clk);
    chk("first frame_start", {31'h0, frame_start}, 32'h1);
    chk("first off", {24'h0, an}, 32'hFF);
    repeat (BC - 1) @(negedge clk);
    chk("first off_last", {24'h0, an}, 32'hFF);
    chk("first fs_low", {31'h0, frame_start}, 32'h0);
    @(negedge clk);
    chk("first an", {24'h0, an}, 32'hFE);
    chk("first seg", {25'h0, seg}, {25'h0, 7'b0000000});
    chk("first dp", {31'h0, dp}, 32'h1);

    // Table: full scan, mid-frame input change, masks/dp, wraps
    for (int i = 0; i < 16; i++) begin
      digits  = tbl[i].d;
      dp_in   = tbl[i].dpi;
      en_mask = tbl[i].en;
      advance($sformatf("row%0d", i), tbl[i].wrap, tbl[i].ea, tbl[i].es, tbl[i].ed);
    end

    // Tick during BLANK is dropped: exactly one advance per SHOW tick
    pulse_tick();
    repeat (4) @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    chk("blank_tick off", {24'h0, an}, 32'hFF);
    repeat (10) @(negedge clk);
    chk("blank_tick off_last", {24'h0, an}, 32'hFF);
    @(negedge clk);
    chk("blank_tick an", {24'h0, an}, 32'hFD);
    chk("blank_tick seg", {25'h0, seg}, {25'h0, 7'b1111000});
    advance("after_drop", 1'b0, 8'hFB, 7'b0000010, 1'b1);

    // Walk to idx 5, then assert reset between clock edges
    advance("walk3", 1'b0, 8'hF7, 7'b0010010, 1'b1);
    advance("walk4", 1'b0, 8'hEF, 7'b0011001, 1'b1);
    advance("walk5", 1'b0, 8'hDF, 7'b0110000, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async an", {24'h0, an}, 32'hFF);
    chk("async seg", {25'h0, seg}, 32'h7F);
    chk("async dp", {31'h0, dp}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("restart frame_start", {31'h0, frame_start}, 32'h1);
    repeat (BC) @(negedge clk);
    chk("restart an", {24'h0, an}, 32'hFE);
    chk("restart seg", {25'h0, seg}, {25'h0, 7'b0000000});

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    begin
      logic [7:0] lz_an  [8];
      logic [6:0] lz_seg [8];
      lz_an[0] = 8'hFD; lz_seg[0] = 7'b1000000;
      lz_an[1] = 8'hFB; lz_seg[1] = 7'b0110000;
      lz_an[2] = 8'hFF; lz_seg[2] = 7'b1000000;
      lz_an[3] = 8'hFF; lz_seg[3] = 7'b1000000;
      lz_an[4] = 8'hFF; lz_seg[4] = 7'b1000000;
      lz_an[5] = 8'hFF; lz_seg[5] = 7'b1000000;
      lz_an[6] = 8'hFF; lz_seg[6] = 7'b1000000;
      lz_an[7] = 8'hFE; lz_seg[7] = 7'b0010010;
      rst_n   = 1'b0;
      digits  = 32'h00000305;
      dp_in   = 8'h00;
      en_mask = 8'hFF;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (BC + 1) @(negedge clk);
      chk("lz d0 an", {24'h0, an}, 32'hFE);
      chk("lz d0 seg", {25'h0, seg}, {25'h0, 7'b0010010});
      for (int i = 0; i < 8; i++)
        advance($sformatf("lz%0d", i + 1), (i == 7), lz_an[i], lz_seg[i], 1'b1);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
